// File: rtl/lock_relock_defs_pkg.sv
// lock_relock_defs: state encodings, lock_ctrl bit positions and timing constants
// shared by the relock sequencer and its window detector.
package lock_relock_defs;
   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_ARM       = 3'd1,
      S_WAIT_TRIG = 3'd2,
      S_SETTLE    = 3'd3,
      S_MONITOR   = 3'd4,
      S_UNLOCK    = 3'd5,
      S_FAIL      = 3'd6
   } seq_state_e;
   localparam int NOW         = 0;
   localparam int LAUNCH      = 1;
   localparam int CUR_LSB     = 2;
   localparam int CUR_MSB     = 5;
   localparam int END_LSB     = 6;
   localparam int END_MSB     = 9;
   localparam int TRIG_TIME   = 10;
   localparam int TRIG_VAL    = 11;
   localparam int UNLOCK_HOLD = 2;
endpackage

// File: rtl/lock_relock_seq_window_det.sv
// lock_window_det: signed window compare with a saturating out-of-window persistence
// counter; pulses lost_o on the cycle the count reaches max(lost_time_i,1).
module lock_window_det #(
   parameter int DW = 14,
   parameter int TW = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 clear_i,
   input  logic signed [DW-1:0] signal_i,
   input  logic signed [DW-1:0] win_lo_i,
   input  logic signed [DW-1:0] win_hi_i,
   input  logic [TW-1:0]        lost_time_i,
   output logic                 lost_o
);
   logic [TW-1:0] cnt_q, cnt_d, thr;
   logic [TW:0]   nxt;
   logic          outside;
   always_comb begin
      outside = (signal_i < win_lo_i) || (signal_i > win_hi_i);
      thr     = (lost_time_i == '0) ? TW'(1) : lost_time_i;
      nxt     = {1'b0, cnt_q} + (TW+1)'(1);
      lost_o  = !clear_i && outside && (nxt >= {1'b0, thr});
      cnt_d   = (clear_i || !outside) ? '0 : ((&cnt_q) ? cnt_q : nxt[TW-1:0]);
   end
   always_ff @(posedge clk) begin
      if (rst) cnt_q <= '0;
      else     cnt_q <= cnt_d;
   end
endmodule

// File: rtl/lock_relock_seq.sv
// lock_relock_seq: supervisory arm/lock/monitor/relock sequencer driving lock_ctrl.
// Define LOCK_RELOCK_LOCKTIME_EN to build the locked_time MONITOR-cycle counter.
module lock_relock_seq
   import lock_relock_defs::*;
#(
   parameter int DW = 14,
   parameter int TW = 32,
   parameter int RW = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 enable,
   input  logic [11:0]          lock_state_in,
   input  logic                 lock_ctrl_trig,
   input  logic signed [DW-1:0] signal,
   input  logic signed [DW-1:0] win_lo,
   input  logic signed [DW-1:0] win_hi,
   input  logic [TW-1:0]        lost_time,
   input  logic [TW-1:0]        settle_time,
   input  logic [TW-1:0]        arm_timeout,
   input  logic [RW-1:0]        max_retries,
   output logic [11:0]          lock_state_out,
   output logic [2:0]           seq_state,
   output logic                 locked,
   output logic                 fail,
   output logic [RW-1:0]        relock_cnt,
   output logic [TW-1:0]        locked_time
);
   seq_state_e    state_q, state_d;
   logic [TW-1:0] timer_q, timer_d;
   logic [RW-1:0] relock_q, relock_d, relock_inc;
   logic          locked_q, fail_q, lost, retry, to_fail, committed;
   lock_window_det #(.DW(DW), .TW(TW)) u_det (
      .clk(clk), .rst(rst), .clear_i(state_q != S_MONITOR), .signal_i(signal),
      .win_lo_i(win_lo), .win_hi_i(win_hi), .lost_time_i(lost_time), .lost_o(lost)
   );
   // One timer serves the arm timeout, settle delay and unlock hold.
   always_comb begin
      state_d    = state_q;
      timer_d    = (&timer_q) ? timer_q : timer_q + TW'(1);
      retry      = 1'b0;
      relock_inc = (&relock_q) ? relock_q : relock_q + RW'(1);
      to_fail    = (max_retries != '0) && (relock_inc > max_retries);
      case (state_q)
         S_IDLE:      if (enable) state_d = S_ARM;
         S_ARM:       begin state_d = S_WAIT_TRIG; timer_d = '0; end
         S_WAIT_TRIG: if (lock_ctrl_trig) begin
                         state_d = S_SETTLE;
                         timer_d = '0;
                      end else if (arm_timeout != '0 && timer_q + TW'(1) == arm_timeout) retry = 1'b1;
         S_SETTLE:    if (timer_q == settle_time) state_d = S_MONITOR;
         S_MONITOR:   if (lost) retry = 1'b1;
         S_UNLOCK:    if (timer_q == TW'(UNLOCK_HOLD - 1)) state_d = S_ARM;
         default:     state_d = state_q;
      endcase
      if (retry) begin
         state_d = to_fail ? S_FAIL : S_UNLOCK;
         timer_d = '0;
      end
      if (!enable) state_d = S_IDLE;
      relock_d = (state_d == S_IDLE) ? '0 : (retry ? relock_inc : relock_q);
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= S_IDLE;
         timer_q  <= '0;
         relock_q <= '0;
         locked_q <= 1'b0;
         fail_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         timer_q  <= timer_d;
         relock_q <= relock_d;
         locked_q <= state_d == S_MONITOR;
         fail_q   <= state_d == S_FAIL;
      end
   end
   // Live config word muxed on registered state so software edits apply at once.
   always_comb begin
      committed      = (state_q == S_SETTLE) || (state_q == S_MONITOR);
      lock_state_out = lock_state_in;
      if (state_q != S_IDLE) begin
         lock_state_out[TRIG_VAL:TRIG_TIME] = lock_state_in[TRIG_VAL:TRIG_TIME];
         lock_state_out[END_MSB:END_LSB]    = lock_state_in[END_MSB:END_LSB];
         lock_state_out[CUR_MSB:CUR_LSB]    = committed ? lock_state_in[END_MSB:END_LSB]
                                                        : lock_state_in[CUR_MSB:CUR_LSB];
         lock_state_out[LAUNCH]             = (state_q == S_ARM) || (state_q == S_WAIT_TRIG);
         lock_state_out[NOW]                = 1'b0;
      end
   end
   assign seq_state  = state_q;
   assign locked     = locked_q;
   assign fail       = fail_q;
   assign relock_cnt = relock_q;
`ifdef LOCK_RELOCK_LOCKTIME_EN
   logic [TW-1:0] lt_q, lt_d;
   always_comb
      lt_d = (state_d == S_IDLE || state_d == S_SETTLE) ? '0
           : ((state_q == S_MONITOR && !(&lt_q)) ? lt_q + TW'(1) : lt_q);
   always_ff @(posedge clk) begin
      if (rst) lt_q <= '0;
      else     lt_q <= lt_d;
   end
   assign locked_time = lt_q;
`else
   assign locked_time = '0;
`endif
endmodule
